lockpick_host: RTL and testbench

- Host-side driver for the lockpick game byte interface.
- Accepts one attempt command carrying two 256-bit keys and opens a game session with a single-cycle start pulse.
- Streams key A and then key B one byte per enable, captures the 32-byte result stream, classifies it, and returns a response to the requesting logic.
- Tracks whether the game is waiting for a retry, so the next attempt skips the start pulse.

---
 rtl/lockpick_pkg.sv | 43 ++++
 rtl/lockpick_msg_classify.sv | 31 +++
 rtl/lockpick_host.sv | 225 ++++++++++++++++++++++
 tb/tb_lockpick_host.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockpick_pkg.sv
// lockpick_pkg: shared types and constants for the lockpick host driver.
//   state_t          - host FSM states
//   RES_*            - classified result codes returned on rsp_result
//   STAT_*           - game_status encodings
//   WORD_*           - 32-bit result patterns the game repeats eight times
//   KEY_BYTES/MSG_BYTES - key and result stream lengths in bytes
package lockpick_pkg;

  localparam int KEY_BYTES = 32;
  localparam int MSG_BYTES = 32;
  localparam int MSG_WORDS = MSG_BYTES / 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND_A,
    ST_SEND_B,
    ST_WAIT_OUT,
    ST_RECV,
    ST_RESP
  } state_t;

  localparam logic [1:0] RES_UNKNOWN = 2'b00;
  localparam logic [1:0] RES_RETRY   = 2'b01;
  localparam logic [1:0] RES_WIN     = 2'b10;
  localparam logic [1:0] RES_LOCKED  = 2'b11;

  localparam logic [1:0] STAT_IDLE   = 2'b00;
  localparam logic [1:0] STAT_ERROR  = 2'b01;
  localparam logic [1:0] STAT_WIN    = 2'b10;
  localparam logic [1:0] STAT_LOCKED = 2'b11;

  localparam logic [31:0] WORD_WIN    = 32'hFACEFACE;
  localparam logic [31:0] WORD_LOCKED = 32'hDEADDEAD;
  localparam logic [31:0] WORD_RETRY  = 32'hBAD0BAD0;

  // Byte idx of a key, byte 0 in the least significant position.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                          input logic [4:0]             idx);
    return key[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/lockpick_msg_classify.sv
// lockpick_msg_classify: combinational classifier of a captured result stream.
//   msg_i    - 256-bit captured message, byte i at [8i+7:8i]
//   result_o - RES_WIN / RES_LOCKED / RES_RETRY when all eight words match
//              the corresponding pattern, RES_UNKNOWN otherwise
module lockpick_msg_classify
  import lockpick_pkg::*;
(
  input  logic [8*MSG_BYTES-1:0] msg_i,
  output logic [1:0]             result_o
);

  logic all_win;
  logic all_locked;
  logic all_retry;

  always_comb begin
    all_win    = 1'b1;
    all_locked = 1'b1;
    all_retry  = 1'b1;
    for (int w = 0; w < MSG_WORDS; w++) begin
      all_win    &= (msg_i[32*w +: 32] == WORD_WIN);
      all_locked &= (msg_i[32*w +: 32] == WORD_LOCKED);
      all_retry  &= (msg_i[32*w +: 32] == WORD_RETRY);
    end
    if (all_win)         result_o = RES_WIN;
    else if (all_locked) result_o = RES_LOCKED;
    else if (all_retry)  result_o = RES_RETRY;
    else                 result_o = RES_UNKNOWN;
  end

endmodule

// File: rtl/lockpick_host.sv
// lockpick_host: host-side driver for the lockpick game byte interface.
//   clk_i, rst_i            - clock, async active-high reset
//   cmd_*                   - attempt command (valid/ready, two 256-bit keys)
//   game_start_o            - one-cycle session start pulse
//   game_input_enable/data  - key bytes, key A then key B, byte 0 first
//   game_output_valid/data  - 32-byte result stream, game_status_i alongside
//   rsp_*                   - classified response (valid/ready)
//   session_open_o          - game waits for a retry; next attempt skips start
//
// state       | meaning
// ST_IDLE     | ready for a command
// ST_START    | game_start pulse
// ST_SEND_A   | streaming key A, BYTE_GAP idle cycles between bytes
// ST_SEND_B   | streaming key B
// ST_WAIT_OUT | waiting for first result byte, bounded by TIMEOUT_CYCLES
// ST_RECV     | capturing result bytes 1..31
// ST_RESP     | response held until rsp_ready
module lockpick_host
  import lockpick_pkg::*;
#(
  parameter int BYTE_GAP       = 0,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [8*KEY_BYTES-1:0] cmd_key_a_i,
  input  logic [8*KEY_BYTES-1:0] cmd_key_b_i,
  output logic                   game_start_o,
  output logic                   game_input_enable_o,
  output logic [7:0]             game_input_data_o,
  input  logic                   game_output_valid_i,
  input  logic [7:0]             game_output_data_i,
  input  logic [1:0]             game_status_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [1:0]             rsp_result_o,
  output logic [1:0]             rsp_status_o,
  output logic                   rsp_error_o,
  output logic [8*MSG_BYTES-1:0] rsp_msg_o,
  output logic                   session_open_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [3:0]             gap_q, gap_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [8*KEY_BYTES-1:0] key_a_q, key_a_d;
  logic [8*KEY_BYTES-1:0] key_b_q, key_b_d;
  logic [8*MSG_BYTES-1:0] msg_q, msg_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   start_q, start_d;
  logic                   en_q, en_d;
  logic [7:0]             data_q, data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [1:0]             result_q, result_d;
  logic [1:0]             status_q, status_d;
  logic                   error_q, error_d;
  logic                   session_q, session_d;
  logic                   abort;
  logic [1:0]             cls;

  lockpick_msg_classify u_classify (
    .msg_i    (msg_d),
    .result_o (cls)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      key_a_q     <= '0;
      key_b_q     <= '0;
      msg_q       <= '0;
      cmd_ready_q <= 1'b0;
      start_q     <= 1'b0;
      en_q        <= 1'b0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      result_q    <= RES_UNKNOWN;
      status_q    <= '0;
      error_q     <= 1'b0;
      session_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      key_a_q     <= key_a_d;
      key_b_q     <= key_b_d;
      msg_q       <= msg_d;
      cmd_ready_q <= cmd_ready_d;
      start_q     <= start_d;
      en_q        <= en_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      status_q    <= status_d;
      error_q     <= error_d;
      session_q   <= session_d;
    end
  end

  // Next state. gap_q counts remaining idle cycles after a sent byte; a
  // SEND cycle with gap_q==0 is the cycle the byte is on the bus.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    key_a_d = key_a_q;
    key_b_d = key_b_q;
    msg_d   = msg_q;
    abort   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          key_a_d = cmd_key_a_i;
          key_b_d = cmd_key_b_i;
          msg_d   = '0;
          cnt_d   = '0;
          gap_d   = '0;
          tmo_d   = '0;
          state_d = session_q ? ST_SEND_A : ST_START;
        end
      end
      ST_START: state_d = ST_SEND_A;
      ST_SEND_A, ST_SEND_B: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          gap_d = 4'(BYTE_GAP);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 5'(KEY_BYTES - 1)) begin
            if (state_q == ST_SEND_A) begin
              state_d = ST_SEND_B;
            end else begin
              state_d = ST_WAIT_OUT;
              gap_d   = '0;
              tmo_d   = '0;
            end
          end
        end
      end
      ST_WAIT_OUT: begin
        if (game_output_valid_i) begin
          msg_d[7:0] = game_output_data_i;
          cnt_d      = 5'd1;
          tmo_d      = '0;
          state_d    = ST_RECV;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
            abort   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RECV: begin
        if (game_output_valid_i) begin
          msg_d[{cnt_q, 3'b000} +: 8] = game_output_data_i;
          cnt_d = cnt_q + 1'b1;
          tmo_d = '0;
          if (cnt_q == 5'(MSG_BYTES - 1)) state_d = ST_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
            abort   = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with the state they belong to.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    start_d     = (state_d == ST_START);
    en_d        = ((state_d == ST_SEND_A) || (state_d == ST_SEND_B)) && (gap_d == '0);
    data_d      = '0;
    if (en_d) begin
      data_d = (state_d == ST_SEND_A) ? key_byte(key_a_d, cnt_d) : key_byte(key_b_d, cnt_d);
    end
    rsp_valid_d = (state_d == ST_RESP);
    result_d    = result_q;
    status_d    = status_q;
    error_d     = error_q;
    session_d   = session_q;
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      if (abort) begin
        result_d = RES_UNKNOWN;
        status_d = '0;
        error_d  = 1'b1;
      end else begin
        result_d = cls;
        status_d = game_status_i;
        error_d  = (cls == RES_UNKNOWN);
      end
      session_d = !abort && (cls == RES_RETRY);
    end
  end

  assign cmd_ready_o         = cmd_ready_q;
  assign game_start_o        = start_q;
  assign game_input_enable_o = en_q;
  assign game_input_data_o   = data_q;
  assign rsp_valid_o         = rsp_valid_q;
  assign rsp_result_o        = result_q;
  assign rsp_status_o        = status_q;
  assign rsp_error_o         = error_q;
  assign rsp_msg_o           = msg_q;
  assign session_open_o      = session_q;

endmodule

// File: tb/tb_lockpick_host.sv
module tb_lockpick_host;
  import lockpick_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         sel;
  logic         cmd_valid;
  logic [255:0] key_a, key_b;
  logic         gov;
  logic [7:0]   god;
  logic [1:0]   gst;
  logic         rsp_ready;

  logic         cr0, gs0, en0, rv0, re0, so0;
  logic [7:0]   d0;
  logic [1:0]   rr0, rs0;
  logic [255:0] m0;
  logic         cr1, gs1, en1, rv1, re1, so1;
  logic [7:0]   d1;
  logic [1:0]   rr1, rs1;
  logic [255:0] m1;

  lockpick_host #(.BYTE_GAP(0), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid & ~sel), .cmd_ready_o(cr0),
    .cmd_key_a_i(key_a), .cmd_key_b_i(key_b), .game_start_o(gs0),
    .game_input_enable_o(en0), .game_input_data_o(d0),
    .game_output_valid_i(gov), .game_output_data_i(god), .game_status_i(gst),
    .rsp_valid_o(rv0), .rsp_ready_i(rsp_ready), .rsp_result_o(rr0), .rsp_status_o(rs0),
    .rsp_error_o(re0), .rsp_msg_o(m0), .session_open_o(so0));

  lockpick_host #(.BYTE_GAP(2), .TIMEOUT_CYCLES(16)) dut_g (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid & sel), .cmd_ready_o(cr1),
    .cmd_key_a_i(key_a), .cmd_key_b_i(key_b), .game_start_o(gs1),
    .game_input_enable_o(en1), .game_input_data_o(d1),
    .game_output_valid_i(gov), .game_output_data_i(god), .game_status_i(gst),
    .rsp_valid_o(rv1), .rsp_ready_i(rsp_ready), .rsp_result_o(rr1), .rsp_status_o(rs1),
    .rsp_error_o(re1), .rsp_msg_o(m1), .session_open_o(so1));

  wire         cmd_ready    = sel ? cr1 : cr0;
  wire         game_start   = sel ? gs1 : gs0;
  wire         game_en      = sel ? en1 : en0;
  wire [7:0]   game_data    = sel ? d1 : d0;
  wire         rsp_valid    = sel ? rv1 : rv0;
  wire [1:0]   rsp_result   = sel ? rr1 : rr0;
  wire [1:0]   rsp_status   = sel ? rs1 : rs0;
  wire         rsp_error    = sel ? re1 : re0;
  wire [255:0] rsp_msg      = sel ? m1 : m0;
  wire         session_open = sel ? so1 : so0;

  // Passive monitor: cycle stamps of enables, starts, acceptance and responses.
  int       cyc = 0, n_en = 0, n_start = 0, n_rsp = 0, acc_cyc = 0, rv_rise = 0;
  logic     rv_prev = 1'b0;
  logic [7:0] byte_log [0:2047];
  int       en_cyc_log [0:2047];

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rv_prev <= rsp_valid;
    if (cmd_valid && cmd_ready) acc_cyc <= cyc;
    if (game_start) n_start <= n_start + 1;
    if (game_en) begin
      byte_log[n_en % 2048]   <= game_data;
      en_cyc_log[n_en % 2048] <= cyc;
      n_en <= n_en + 1;
    end
    if (rsp_valid && !rv_prev) begin
      n_rsp   <= n_rsp + 1;
      rv_rise <= cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [255:0] ka;
    logic [255:0] kb;
    logic [31:0]  word;
    int           nbytes;
    logic [1:0]   status;
    int           corrupt;
    int           rdy_delay;
    logic [1:0]   exp_result;
    logic [1:0]   exp_status;
    logic         exp_error;
    logic         exp_session;
    int           exp_starts;
  } vec_t;

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int base_en, base_st, spacing, bad, sp_bad, t;
    logic [255:0] exp_msg;
    logic [7:0] b;
    spacing = sel ? 3 : 1;
    exp_msg = '0;
    @(negedge clk);
    base_en   = n_en;
    base_st   = n_start;
    rsp_ready = (v.rdy_delay == 0);
    gst       = v.status;
    key_a     = v.ka;
    key_b     = v.kb;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while ((n_en - base_en) < 64 && t < 1000) begin @(negedge clk); t++; end
    chk("enable_count", n_en - base_en, 64);
    bad = 0;
    sp_bad = 0;
    for (int i = 0; i < 64; i++) begin
      b = (i < 32) ? v.ka[8*i +: 8] : v.kb[8*(i-32) +: 8];
      if (byte_log[(base_en + i) % 2048] !== b) bad++;
      if (i > 0 && (en_cyc_log[(base_en + i) % 2048] - en_cyc_log[(base_en + i - 1) % 2048]) != spacing)
        sp_bad++;
    end
    chk("key_bytes", bad, 0);
    chk("enable_spacing", sp_bad, 0);
    chk("first_enable_latency", en_cyc_log[base_en % 2048] - acc_cyc, (v.exp_starts != 0) ? 2 : 1);
    repeat (3) @(negedge clk);
    for (int i = 0; i < v.nbytes; i++) begin
      b = v.word[8*(i%4) +: 8];
      if ((i / 4) == v.corrupt) b ^= 8'h01;
      gov = 1'b1;
      god = b;
      exp_msg[8*i +: 8] = b;
      @(negedge clk);
    end
    gov = 1'b0;
    god = 8'h00;
    t = 0;
    while (!rsp_valid && t < 200) begin @(negedge clk); t++; end
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_result", rsp_result, v.exp_result);
    chk("rsp_status", rsp_status, v.exp_status);
    chk("rsp_error", rsp_error, v.exp_error);
    chk("rsp_msg", rsp_msg, exp_msg);
    chk("session_open", session_open, v.exp_session);
    chk("cmd_ready_busy", cmd_ready, 1'b0);
    if (v.rdy_delay == 0) begin
      @(negedge clk);
      chk("rsp_valid_one_cycle", rsp_valid, 1'b0);
    end else begin
      bad = 0;
      for (int i = 0; i < v.rdy_delay; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_result !== v.exp_result || rsp_status !== v.exp_status ||
            rsp_error !== v.exp_error || rsp_msg !== exp_msg)
          bad++;
      end
      chk("rsp_hold", bad, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rsp_drop", rsp_valid, 1'b0);
    end
    rsp_ready = 1'b0;
    chk("cmd_ready_after", cmd_ready, 1'b1);
    chk("start_pulses", n_start - base_st, v.exp_starts);
    if (v.nbytes == 0)
      chk("timeout_latency", rv_rise - en_cyc_log[(base_en + 63) % 2048], 17);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  vec_t         vecs [0:8];
  vec_t         gv;
  logic [255:0] kinc, kdec, krnd;
  int           base, base2, nrsp0, t;

  initial begin
    rst = 1'b1; sel = 1'b0; cmd_valid = 1'b0; key_a = '0; key_b = '0;
    gov = 1'b0; god = '0; gst = '0; rsp_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      kinc[8*i +: 8] = 8'(i);
      kdec[8*i +: 8] = 8'(255 - i);
    end
    for (int i = 0; i < 8; i++) krnd[32*i +: 32] = $urandom;

    //          ka    kb    word         n   st     cor rdy res          exst   err   ses  starts
    vecs[0] = '{'0,   '0,   WORD_WIN,    32, 2'b10, -1, 0, RES_WIN,     2'b10, 1'b0, 1'b0, 1};
    vecs[1] = '{kinc, kdec, WORD_RETRY,  32, 2'b01, -1, 0, RES_RETRY,   2'b01, 1'b0, 1'b1, 1};
    vecs[2] = '{kdec, kinc, WORD_RETRY,  32, 2'b01, -1, 0, RES_RETRY,   2'b01, 1'b0, 1'b1, 0};
    vecs[3] = '{krnd, kinc, WORD_LOCKED, 32, 2'b11, -1, 0, RES_LOCKED,  2'b11, 1'b0, 1'b0, 0};
    vecs[4] = '{kinc, krnd, WORD_WIN,    32, 2'b10,  3, 0, RES_UNKNOWN, 2'b10, 1'b1, 1'b0, 1};
    vecs[5] = '{krnd, krnd, WORD_WIN,    20, 2'b10, -1, 0, RES_UNKNOWN, 2'b00, 1'b1, 1'b0, 1};
    vecs[6] = '{kinc, kinc, WORD_RETRY,  32, 2'b01, -1, 0, RES_RETRY,   2'b01, 1'b0, 1'b1, 1};
    vecs[7] = '{kdec, kdec, WORD_WIN,     0, 2'b00, -1, 0, RES_UNKNOWN, 2'b00, 1'b1, 1'b0, 0};
    vecs[8] = '{krnd, kdec, WORD_WIN,    32, 2'b10, -1, 3, RES_WIN,     2'b10, 1'b0, 1'b0, 1};

    #1;
    chk("reset_outputs", {cmd_ready, game_start, game_en, game_data, rsp_valid,
                          rsp_result, rsp_status, rsp_error, session_open}, '0);
    chk("reset_msg", rsp_msg, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ready", cmd_ready, 1'b1);

    for (int k = 0; k < 9; k++) run_vec(vecs[k]);

    // Gapped instance with a slow response consumer.
    sel = 1'b1;
    pulse_reset();
    gv = '{kinc, kdec, WORD_WIN, 32, 2'b10, -1, 5, RES_WIN, 2'b10, 1'b0, 1'b0, 1};
    run_vec(gv);

    // Reset during key B streaming aborts without a response.
    sel = 1'b0;
    pulse_reset();
    base  = n_en;
    nrsp0 = n_rsp;
    key_a = kinc;
    key_b = kdec;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    t = 0;
    while ((n_en - base) < 40 && t < 500) begin @(negedge clk); t++; end
    chk("reached_send_b", (n_en - base) >= 40, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_abort_outputs", {cmd_ready, game_start, game_en, game_data, rsp_valid,
                              rsp_result, rsp_status, rsp_error, session_open}, '0);
    chk("rst_abort_msg", rsp_msg, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base2 = n_en;
    repeat (40) @(negedge clk);
    chk("rst_no_response", n_rsp - nrsp0, 0);
    chk("rst_no_enables", n_en - base2, 0);
    chk("rst_idle_ready", cmd_ready, 1'b1);
    rsp_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
